// File: rtl/sdram_master_pkg.sv
// Shared types and defaults for the SDRAM request-side master: FSM states,
// grant direction encoding and default address/burst widths.
package sdram_master_pkg;

  localparam int ADDR_W_DEF  = 24;
  localparam int BURST_W_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_REQ   = 3'd1,
    ST_WR_BURST = 3'd2,
    ST_RD_REQ   = 3'd3,
    ST_RD_BURST = 3'd4
  } state_e;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

endpackage

// File: rtl/sdram_addr_gen.sv
// Wrapping burst address generator for one direction: holds the next burst
// start address and defers a load that arrives while its own burst is in flight.
module sdram_addr_gen
  import sdram_master_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               active_i,
  input  logic               done_i,
  input  logic [BURST_W-1:0] burst_i,
  input  logic [ADDR_W-1:0]  min_i,
  input  logic [ADDR_W-1:0]  max_i,
  output logic [ADDR_W-1:0]  addr_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic [ADDR_W:0]   sum;
  logic              wrap;

  // One extra bit so a sum past the top of the address space still wraps.
  assign sum  = {1'b0, addr_q} + (ADDR_W+1)'(burst_i);
  assign wrap = sum >= {1'b0, max_i};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    addr_d = addr_q;
    pend_d = pend_q;
    if (done_i) begin
      pend_d = 1'b0;
      if (pend_q || load_i || wrap) addr_d = min_i;
      else                          addr_d = sum[ADDR_W-1:0];
    end else if (load_i) begin
      if (active_i) pend_d = 1'b1;
      else          addr_d = min_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      pend_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      pend_q <= pend_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/sdram_fifo_master.sv
// Request-side SDRAM master: arbitrates write/read bursts from FIFO levels,
// runs the req/ack handshake and mirrors ack windows as FIFO strobes.
module sdram_fifo_master
  import sdram_master_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int BURST_W       = BURST_W_DEF,
  parameter int RD_FIFO_DEPTH = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sdram_init_done_i,
  input  logic [BURST_W-1:0] wr_fifo_level_i,
  input  logic [BURST_W-1:0] rd_fifo_level_i,
  input  logic [BURST_W-1:0] wr_burst_len_i,
  input  logic [BURST_W-1:0] rd_burst_len_i,
  input  logic [ADDR_W-1:0]  wr_min_addr_i,
  input  logic [ADDR_W-1:0]  wr_max_addr_i,
  input  logic [ADDR_W-1:0]  rd_min_addr_i,
  input  logic [ADDR_W-1:0]  rd_max_addr_i,
  input  logic               wr_load_i,
  input  logic               rd_load_i,
  input  logic               rd_enable_i,
  input  logic               sdram_wr_ack_i,
  input  logic               sdram_rd_ack_i,
  output logic               sdram_wr_req_o,
  output logic               sdram_rd_req_o,
  output logic [BURST_W-1:0] sdram_wr_burst_o,
  output logic [BURST_W-1:0] sdram_rd_burst_o,
  output logic [ADDR_W-1:0]  sdram_wr_addr_o,
  output logic [ADDR_W-1:0]  sdram_rd_addr_o,
  output logic               wr_fifo_rden_o,
  output logic               rd_fifo_wren_o,
  output logic               busy_o
);

  state_e             state_q;
  grant_e             last_grant_q;
  logic               wr_req_q, rd_req_q;
  logic [BURST_W-1:0] wr_burst_q, rd_burst_q;

  logic               wr_elig, rd_elig, grant_wr;
  logic [BURST_W:0]   rd_sum;
  logic               wr_done, rd_done, wr_active, rd_active;

  assign wr_elig = sdram_init_done_i && (wr_burst_len_i != '0)
                   && (wr_fifo_level_i >= wr_burst_len_i);

  // Widened sum so a large level plus burst cannot wrap back under the depth.
  assign rd_sum  = {1'b0, rd_fifo_level_i} + {1'b0, rd_burst_len_i};
  assign rd_elig = sdram_init_done_i && rd_enable_i && (rd_burst_len_i != '0)
                   && (rd_sum <= (BURST_W+1)'(RD_FIFO_DEPTH));

  assign grant_wr = wr_elig && (!rd_elig || last_grant_q == GRANT_RD);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_RD;
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      wr_burst_q   <= '0;
      rd_burst_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_wr) begin
            wr_burst_q <= wr_burst_len_i;
            wr_req_q   <= 1'b1;
            state_q    <= ST_WR_REQ;
          end else if (rd_elig) begin
            rd_burst_q <= rd_burst_len_i;
            rd_req_q   <= 1'b1;
            state_q    <= ST_RD_REQ;
          end
        end
        ST_WR_REQ: begin
          if (sdram_wr_ack_i) begin
            wr_req_q <= 1'b0;
            state_q  <= ST_WR_BURST;
          end
        end
        ST_WR_BURST: begin
          if (!sdram_wr_ack_i) begin
            last_grant_q <= GRANT_WR;
            state_q      <= ST_IDLE;
          end
        end
        ST_RD_REQ: begin
          if (sdram_rd_ack_i) begin
            rd_req_q <= 1'b0;
            state_q  <= ST_RD_BURST;
          end
        end
        ST_RD_BURST: begin
          if (!sdram_rd_ack_i) begin
            last_grant_q <= GRANT_RD;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_active = (state_q == ST_WR_REQ) || (state_q == ST_WR_BURST);
  assign rd_active = (state_q == ST_RD_REQ) || (state_q == ST_RD_BURST);
  assign wr_done   = (state_q == ST_WR_BURST) && !sdram_wr_ack_i;
  assign rd_done   = (state_q == ST_RD_BURST) && !sdram_rd_ack_i;

  sdram_addr_gen #(.ADDR_W(ADDR_W), .BURST_W(BURST_W)) u_wr_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (wr_load_i),
    .active_i (wr_active),
    .done_i   (wr_done),
    .burst_i  (wr_burst_q),
    .min_i    (wr_min_addr_i),
    .max_i    (wr_max_addr_i),
    .addr_o   (sdram_wr_addr_o)
  );

  sdram_addr_gen #(.ADDR_W(ADDR_W), .BURST_W(BURST_W)) u_rd_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (rd_load_i),
    .active_i (rd_active),
    .done_i   (rd_done),
    .burst_i  (rd_burst_q),
    .min_i    (rd_min_addr_i),
    .max_i    (rd_max_addr_i),
    .addr_o   (sdram_rd_addr_o)
  );

  assign sdram_wr_req_o   = wr_req_q;
  assign sdram_rd_req_o   = rd_req_q;
  assign sdram_wr_burst_o = wr_burst_q;
  assign sdram_rd_burst_o = rd_burst_q;
  assign wr_fifo_rden_o   = sdram_wr_ack_i;
  assign rd_fifo_wren_o   = sdram_rd_ack_i;
  assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_fifo_master.sv
// Directed bench for sdram_fifo_master: eligibility vector table from reset,
// then handshake, wrap, arbitration, throttling, load and reset sequences.
module tb_sdram_fifo_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic [9:0]  wr_lvl, rd_lvl, wr_len, rd_len;
  logic [23:0] wr_min, wr_max, rd_min, rd_max;
  logic        wr_load, rd_load, rd_en, wr_ack, rd_ack;
  logic        wr_req, rd_req, wr_rden, rd_wren, busy;
  logic [9:0]  wr_burst, rd_burst;
  logic [23:0] wr_addr, rd_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdram_fifo_master dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sdram_init_done_i (init_done),
    .wr_fifo_level_i   (wr_lvl),
    .rd_fifo_level_i   (rd_lvl),
    .wr_burst_len_i    (wr_len),
    .rd_burst_len_i    (rd_len),
    .wr_min_addr_i     (wr_min),
    .wr_max_addr_i     (wr_max),
    .rd_min_addr_i     (rd_min),
    .rd_max_addr_i     (rd_max),
    .wr_load_i         (wr_load),
    .rd_load_i         (rd_load),
    .rd_enable_i       (rd_en),
    .sdram_wr_ack_i    (wr_ack),
    .sdram_rd_ack_i    (rd_ack),
    .sdram_wr_req_o    (wr_req),
    .sdram_rd_req_o    (rd_req),
    .sdram_wr_burst_o  (wr_burst),
    .sdram_rd_burst_o  (rd_burst),
    .sdram_wr_addr_o   (wr_addr),
    .sdram_rd_addr_o   (rd_addr),
    .wr_fifo_rden_o    (wr_rden),
    .rd_fifo_wren_o    (rd_wren),
    .busy_o            (busy)
  );

  typedef struct {
    string      name;
    logic       init;
    logic [9:0] wl, wn, rl, rn;
    logic       ren;
    logic       exp_wr, exp_rd;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input logic [63:0] act, input logic [63:0] exp, input string name);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_ack = 1'b0; rd_ack = 1'b0; wr_load = 1'b0; rd_load = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  // Waits for a request, checks it, then plays the controller for n_ack ack cycles.
  task automatic serve(input logic exp_rd, input logic [23:0] exp_addr, input logic [9:0] exp_len,
                       input int n_ack, input logic load_mid, input logic [23:0] exp_next);
    int   waited = 0;
    int   pulses = 0;
    logic got_rd;
    while (!wr_req && !rd_req && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) begin
      check(1'b0, 1'b1, "req_timeout");
      return;
    end
    got_rd = rd_req;
    check(got_rd, exp_rd, "grant_dir");
    check(got_rd ? rd_addr : wr_addr, exp_addr, "req_addr");
    check(got_rd ? rd_burst : wr_burst, exp_len, "req_burst");
    check(busy, 1'b1, "busy_req");
    tick();
    check(got_rd ? rd_req : wr_req, 1'b1, "req_hold");
    if (got_rd) rd_ack = 1'b1; else wr_ack = 1'b1;
    for (int i = 0; i < n_ack; i++) begin
      pulses += int'(got_rd ? rd_wren : wr_rden);
      if (got_rd) rd_load = load_mid && (i == 1);
      else        wr_load = load_mid && (i == 1);
      tick();
      if (i == 0) check(got_rd ? rd_req : wr_req, 1'b0, "req_drop");
    end
    wr_ack = 1'b0; rd_ack = 1'b0; wr_load = 1'b0; rd_load = 1'b0;
    check(pulses, n_ack, "strobe_count");
    check(got_rd ? rd_addr : wr_addr, exp_addr, "addr_stable");
    check(busy, 1'b1, "busy_burst");
    tick();
    check(busy, 1'b0, "busy_idle");
    check(got_rd ? rd_addr : wr_addr, exp_next, "addr_next");
  endtask

  initial begin
    logic seen;
    vecs[0]  = '{"no_init",      1'b0, 10'd512,  10'd256,  10'd0,    10'd256,  1'b1, 1'b0, 1'b0};
    vecs[1]  = '{"wr_short",     1'b1, 10'd255,  10'd256,  10'd0,    10'd256,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"wr_exact",     1'b1, 10'd256,  10'd256,  10'd0,    10'd256,  1'b0, 1'b1, 1'b0};
    vecs[3]  = '{"wr_len0",      1'b1, 10'd100,  10'd0,    10'd0,    10'd256,  1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"rd_fill_full", 1'b1, 10'd0,    10'd256,  10'd256,  10'd256,  1'b1, 1'b0, 1'b1};
    vecs[5]  = '{"rd_300",       1'b1, 10'd0,    10'd256,  10'd300,  10'd256,  1'b1, 1'b0, 1'b0};
    vecs[6]  = '{"rd_257",       1'b1, 10'd0,    10'd256,  10'd257,  10'd256,  1'b1, 1'b0, 1'b0};
    vecs[7]  = '{"rd_disabled",  1'b1, 10'd0,    10'd256,  10'd0,    10'd256,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{"rd_len0",      1'b1, 10'd0,    10'd256,  10'd0,    10'd0,    1'b1, 1'b0, 1'b0};
    vecs[9]  = '{"tie_first_wr", 1'b1, 10'd256,  10'd256,  10'd0,    10'd256,  1'b1, 1'b1, 1'b0};
    vecs[10] = '{"rd_sum_wide",  1'b1, 10'd0,    10'd256,  10'd1000, 10'd100,  1'b1, 1'b0, 1'b0};
    vecs[11] = '{"wr_max_len",   1'b1, 10'd1023, 10'd1023, 10'd0,    10'd0,    1'b0, 1'b1, 1'b0};

    init_done = 1'b0; wr_lvl = '0; rd_lvl = '0; wr_len = '0; rd_len = '0; rd_en = 1'b0;
    wr_min = 24'd0; wr_max = 24'd1024; rd_min = 24'd0; rd_max = 24'd1024;
    tick();
    do_reset();
    check({wr_req, rd_req, busy}, 3'b000, "reset_ctrl");
    check({wr_burst, rd_burst}, 20'd0, "reset_burst");
    check({wr_addr, rd_addr}, 48'd0, "reset_addr");

    foreach (vecs[k]) begin
      do_reset();
      init_done = vecs[k].init; wr_lvl = vecs[k].wl; wr_len = vecs[k].wn;
      rd_lvl = vecs[k].rl; rd_len = vecs[k].rn; rd_en = vecs[k].ren;
      tick();
      check({wr_req, rd_req}, {vecs[k].exp_wr, vecs[k].exp_rd}, vecs[k].name);
      check(busy, vecs[k].exp_wr | vecs[k].exp_rd, {vecs[k].name, "_busy"});
      check(wr_burst, vecs[k].exp_wr ? vecs[k].wn : 10'd0, {vecs[k].name, "_wburst"});
      check(rd_burst, vecs[k].exp_rd ? vecs[k].rn : 10'd0, {vecs[k].name, "_rburst"});
    end

    // Write single burst with full 256-word ack window.
    do_reset();
    init_done = 1'b1; rd_en = 1'b0; rd_len = '0; wr_len = 10'd256; wr_lvl = 10'd255;
    tick();
    check(wr_req, 1'b0, "wr_below_level");
    wr_lvl = 10'd256;
    tick();
    check(wr_req, 1'b1, "wr_req_latency");
    serve(1'b0, 24'd0, 10'd256, 256, 1'b0, 24'd256);
    wr_lvl = '0;

    // Write wrap over a 768-word window.
    do_reset();
    wr_max = 24'd768;
    wr_lvl = 10'd256; serve(1'b0, 24'd0,   10'd256, 3, 1'b0, 24'd256); wr_lvl = '0; tick();
    wr_lvl = 10'd256; serve(1'b0, 24'd256, 10'd256, 3, 1'b0, 24'd512); wr_lvl = '0; tick();
    wr_lvl = 10'd256; serve(1'b0, 24'd512, 10'd256, 3, 1'b0, 24'd0);   wr_lvl = '0;

    // Tie arbitration alternates starting with write.
    do_reset();
    wr_max = 24'd1024; wr_lvl = 10'd512; rd_lvl = '0; rd_len = 10'd256; rd_en = 1'b1;
    serve(1'b0, 24'd0,   10'd256, 2, 1'b0, 24'd256);
    serve(1'b1, 24'd0,   10'd256, 2, 1'b0, 24'd256);
    serve(1'b0, 24'd256, 10'd256, 2, 1'b0, 24'd512);
    serve(1'b1, 24'd256, 10'd256, 2, 1'b0, 24'd512);

    // Read throttling by read FIFO headroom.
    do_reset();
    wr_len = '0; wr_lvl = '0; rd_lvl = 10'd300;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= rd_req;
    end
    check(seen, 1'b0, "rd_throttled");
    rd_lvl = 10'd256;
    serve(1'b1, 24'd0, 10'd256, 4, 1'b0, 24'd256);
    rd_en = 1'b0;

    // Load in IDLE is immediate; load mid-burst is deferred to completion.
    do_reset();
    wr_min = 24'd512; wr_max = 24'd4096; wr_len = 10'd256; wr_lvl = '0;
    wr_load = 1'b1;
    tick();
    wr_load = 1'b0;
    check(wr_addr, 24'd512, "load_idle");
    wr_min = 24'd64; wr_lvl = 10'd256;
    serve(1'b0, 24'd512, 10'd256, 4, 1'b1, 24'd64);
    wr_lvl = '0; tick();
    wr_lvl = 10'd256;
    serve(1'b0, 24'd64, 10'd256, 2, 1'b0, 24'd320);
    wr_lvl = '0;

    // Asynchronous reset during a read burst.
    do_reset();
    wr_len = '0; rd_lvl = '0; rd_len = 10'd64; rd_en = 1'b1;
    tick();
    check(rd_req, 1'b1, "rst_rd_req");
    rd_ack = 1'b1;
    tick();
    tick();
    check(busy, 1'b1, "rst_busy_before");
    #2;
    rst_n = 1'b0;
    #1;
    check({wr_req, rd_req, busy}, 3'b000, "rst_mid_burst");
    rd_ack = 1'b0; rd_en = 1'b0;
    rst_n = 1'b1;

    // Without init_done nothing is ever requested.
    init_done = 1'b0; wr_len = 10'd256; wr_lvl = 10'd512; rd_len = 10'd256; rd_lvl = '0; rd_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      seen |= wr_req | rd_req | busy;
    end
    check(seen, 1'b0, "init_gating");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
